// File: rtl/dac_sweep_ctrl.sv
// dac_sweep_ctrl
// Sweeps the DAC0 counter of the DAC/comparator macro through every code,
// waits SETTLE cycles after each step, samples the selected comparator pair
// and records the first code at which it trips (VoutP=1, VoutM=0).
//
// Ports:
//   clk, rst_n           clock (shared with the comparators), async low reset
//   start                begin a sweep (sampled only while idle)
//   ref_step             one DAC1 step pulse request (idle only, start wins)
//   comp_sel[1:0]        pair select: 0 NAND, 1 AO22, 2 MX21, 3 -> NAND
//   comp_p/comp_m[2:0]   raw asynchronous VoutP/VoutM of the three pairs
//   cnt0_clk, cnt1_clk   DAC0/DAC1 counter step pulses (registered)
//   en0, en1             DAC0/DAC1 counter enables
//   busy, done           sweep in progress / one-cycle end-of-sweep pulse
//   code                 DAC0 code as tracked here (matches the macro counter)
//   trip_valid/trip_code result of the last sweep, held until the next start
module dac_sweep_ctrl #(
    parameter int CODE_W = 4,
    parameter int SETTLE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ref_step,
    input  logic [1:0]        comp_sel,
    input  logic [2:0]        comp_p,
    input  logic [2:0]        comp_m,
    output logic              cnt0_clk,
    output logic              cnt1_clk,
    output logic              en0,
    output logic              en1,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] code,
    output logic              trip_valid,
    output logic [CODE_W-1:0] trip_code
);

    localparam int                CNT_W     = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [CODE_W-1:0] CODE_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SAMPLE, S_STEP, S_WRAP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [1:0]          sel_q, sel_d;
    logic                tv_q, tv_d;
    logic [CODE_W-1:0]   tc_q, tc_d;
    logic                cnt0_q, cnt0_d;
    logic                cnt1_q, cnt1_d;
    logic                en1_q, en1_d;

    // Two-stage synchronizer on {VoutP, VoutM}; stage [1] is the usable copy.
    logic [1:0][5:0]     sync_q;
    logic [2:0]          p_s, m_s;
    logic                hit;

    assign p_s = sync_q[1][5:3];
    assign m_s = sync_q[1][2:0];

    always_comb begin
        case (sel_q)
            2'd1:    hit = p_s[1] & ~m_s[1];
            2'd2:    hit = p_s[2] & ~m_s[2];
            default: hit = p_s[0] & ~m_s[0];   // 0 and 3 both mean NAND
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        sel_d   = sel_q;
        tv_d    = tv_q;
        tc_d    = tc_q;
        cnt0_d  = 1'b0;
        cnt1_d  = 1'b0;
        en1_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LD;
                    sel_d   = comp_sel;
                    tv_d    = 1'b0;
                    tc_d    = '0;
                    code_d  = '0;
                end else if (ref_step) begin
                    cnt1_d = 1'b1;
                    en1_d  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(1)) state_d = S_SAMPLE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            S_SAMPLE: begin
                if (hit && !tv_q) begin
                    tv_d = 1'b1;
                    tc_d = code_q;
                end
                // The step pulse is registered, so it rises on the same edge
                // that advances code: code always mirrors the macro counter.
                cnt0_d = 1'b1;
                if (code_q == CODE_MAX) begin
                    state_d = S_WRAP;
                    code_d  = '0;
                end else begin
                    state_d = S_STEP;
                    code_d  = code_q + CODE_W'(1);
                end
            end
            S_STEP: begin
                cnt_d   = SETTLE_LD;
                state_d = S_SETTLE;
            end
            S_WRAP:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            sel_q   <= '0;
            tv_q    <= 1'b0;
            tc_q    <= '0;
            cnt0_q  <= 1'b0;
            cnt1_q  <= 1'b0;
            en1_q   <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            sel_q   <= sel_d;
            tv_q    <= tv_d;
            tc_q    <= tc_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            en1_q   <= en1_d;
            sync_q  <= {sync_q[0], comp_p, comp_m};
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign en0        = busy;
    assign done       = (state_q == S_DONE);
    assign cnt0_clk   = cnt0_q;
    assign cnt1_clk   = cnt1_q;
    assign en1        = en1_q;
    assign code       = code_q;
    assign trip_valid = tv_q;
    assign trip_code  = tc_q;

endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// Directed bench for dac_sweep_ctrl (defaults CODE_W=4, SETTLE=3).
// Busy cycles are numbered from 1 (the cycle after start is sampled); the
// sample of code k happens in busy cycle 4+5k, done in cycle 81.
module tb_dac_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, ref_step;
    logic [1:0] comp_sel;
    logic [2:0] comp_p, comp_m;
    logic       cnt0_clk, cnt1_clk, en0, en1, busy, done, trip_valid;
    logic [3:0] code, trip_code;

    dac_sweep_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ref_step(ref_step),
        .comp_sel(comp_sel), .comp_p(comp_p), .comp_m(comp_m),
        .cnt0_clk(cnt0_clk), .cnt1_clk(cnt1_clk), .en0(en0), .en1(en1),
        .busy(busy), .done(done), .code(code),
        .trip_valid(trip_valid), .trip_code(trip_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // stimulus controls: mode 0 quiet, 1 trip pair once pulses>=thr,
    // 2 trip pair from cycle c_on until cycle c_off (0 = never clear)
    int mode, pair, thr, c_on, c_off, stop_at_pulse;

    // sweep observations
    int busy_cyc, pulses, cnt1_n, en0_cyc, consec_err, code_err, done_cyc;
    int code_done, tv_done, tc_done, post_busy, post_done;
    bit done_seen;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int ovec();
        return int'({cnt0_clk, cnt1_clk, en0, en1, busy, done, code, trip_valid, trip_code});
    endfunction

    task automatic clr_stim();
        mode = 0; stop_at_pulse = 0; c_off = 0;
        comp_p = 3'b000; comp_m = 3'b111;
    endtask

    task automatic set_pair(input int idx, input bit trip);
        comp_p[idx] = trip;
        comp_m[idx] = ~trip;
    endtask

    // Called at a negedge in IDLE. Issues start, then also pokes start,
    // ref_step and comp_sel at cycle 20, all of which must be ignored.
    task automatic run_sweep(input logic [1:0] sel, input bit with_ref, input bit hold);
        int  cyc;
        bit  fin;
        bit  prev_c0;
        comp_sel = sel; start = 1'b1; ref_step = with_ref;
        busy_cyc = 0; pulses = 0; cnt1_n = 0; en0_cyc = 0; consec_err = 0;
        code_err = 0; done_cyc = 0; done_seen = 0; prev_c0 = 0;
        cyc = 0; fin = 0;
        @(negedge clk);
        while (!fin) begin
            cyc++;
            if (cnt0_clk) begin
                pulses++;
                if (prev_c0) consec_err++;
                if (code != 4'(pulses)) code_err++;
            end
            prev_c0 = cnt0_clk;
            if (busy) busy_cyc++;
            if (en0) en0_cyc++;
            if (cnt1_clk) cnt1_n++;
            if (done) begin
                done_seen = 1; done_cyc = cyc; fin = 1;
                code_done = code; tv_done = trip_valid; tc_done = trip_code;
            end else if (stop_at_pulse != 0 && pulses == stop_at_pulse) begin
                fin = 1;
            end else if (cyc >= 200) begin
                fin = 1;
            end else begin
                if (cyc == 1 || cyc == 21) begin
                    if (!hold) start = 1'b0;
                    ref_step = 1'b0;
                end
                if (cyc == 20) begin
                    start = 1'b1; ref_step = 1'b1; comp_sel = sel ^ 2'b01;
                end
                if (mode == 1 && pulses >= thr) set_pair(pair, 1'b1);
                if (mode == 2 && cyc == c_on) set_pair(pair, 1'b1);
                if (mode == 2 && cyc == c_off) set_pair(pair, 1'b0);
                @(negedge clk);
            end
        end
        if (done_seen) begin
            @(negedge clk);
            post_busy = busy; post_done = done;
        end
    endtask

    task automatic check_sweep(input string tag, input int exp_tv, input int exp_tc);
        chk({tag, "_done_seen"}, done_seen, 1);
        chk({tag, "_busy_len"}, busy_cyc, 81);
        chk({tag, "_done_cyc"}, done_cyc, 81);
        chk({tag, "_cnt0_pulses"}, pulses, 16);
        chk({tag, "_cnt0_consec"}, consec_err, 0);
        chk({tag, "_code_track"}, code_err, 0);
        chk({tag, "_en0_cyc"}, en0_cyc, 81);
        chk({tag, "_cnt1_pulses"}, cnt1_n, 0);
        chk({tag, "_code_at_done"}, code_done, 0);
        chk({tag, "_trip_valid"}, tv_done, exp_tv);
        chk({tag, "_trip_code"}, tc_done, exp_tc);
        chk({tag, "_busy_after"}, post_busy, 0);
        chk({tag, "_done_width"}, post_done, 0);
    endtask

    initial begin
        int n1, ne1, k;
        rst_n = 1'b0; start = 1'b0; ref_step = 1'b0; comp_sel = 2'd0;
        clr_stim();
        repeat (3) @(negedge clk);
        chk("reset_outputs", ovec(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", ovec(), 0);

        // ref_step in IDLE: exactly one registered cnt1_clk/en1 cycle
        ref_step = 1'b1;
        @(negedge clk);
        ref_step = 1'b0;
        n1 = 0; ne1 = 0;
        for (int i = 0; i < 4; i++) begin
            if (cnt1_clk) n1++;
            if (en1) ne1++;
            @(negedge clk);
        end
        chk("ref_idle_cnt1", n1, 1);
        chk("ref_idle_en1", ne1, 1);
        chk("ref_idle_busy", busy, 0);

        // AO22 trips once the macro counter has reached 9
        clr_stim(); mode = 1; pair = 1; thr = 9;
        run_sweep(2'd1, 1'b0, 1'b0);
        check_sweep("ao22_trip9", 1, 9);
        clr_stim();
        repeat (5) @(negedge clk);
        chk("result_hold_tv", trip_valid, 1);
        chk("result_hold_tc", trip_code, 9);

        // no trip; start and ref_step together: sweep wins, no DAC1 pulse
        run_sweep(2'd0, 1'b1, 1'b0);
        check_sweep("notrip_startref", 0, 0);

        // comp_sel=3 is NAND: pair 0 trips at code 4
        clr_stim(); mode = 1; pair = 0; thr = 4;
        run_sweep(2'd3, 1'b0, 1'b0);
        check_sweep("sel3_nand", 1, 4);

        // same stimulus with MX21 selected: nothing seen
        clr_stim(); mode = 1; pair = 0; thr = 4;
        run_sweep(2'd2, 1'b0, 1'b0);
        check_sweep("sel2_mx21", 0, 0);

        // one-cycle glitch right before the code-6 sample edge
        clr_stim(); mode = 2; pair = 1; c_on = 33; c_off = 34;
        run_sweep(2'd1, 1'b0, 1'b0);
        check_sweep("glitch", 0, 0);

        // change too late for code 6 (under 2 synchronizer cycles) -> code 7
        clr_stim(); mode = 2; pair = 1; c_on = 33;
        run_sweep(2'd1, 1'b0, 1'b0);
        check_sweep("late_chg", 1, 7);

        // change just early enough for code 6
        clr_stim(); mode = 2; pair = 1; c_on = 32;
        run_sweep(2'd1, 1'b0, 1'b0);
        check_sweep("edge_chg", 1, 6);

        // start held high: one idle cycle, then the next sweep
        clr_stim();
        run_sweep(2'd0, 1'b0, 1'b1);
        check_sweep("hold_start", 0, 0);
        @(negedge clk);
        chk("hold_restart_busy", busy, 1);
        start = 1'b0;
        k = 1;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("hold_second_len", k, 81);
        @(negedge clk);

        // reset mid-sweep at code 5, after a trip was already recorded
        clr_stim(); mode = 1; pair = 1; thr = 2; stop_at_pulse = 5;
        run_sweep(2'd1, 1'b0, 1'b0);
        chk("mid_code", code, 5);
        chk("mid_trip_valid", trip_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", ovec(), 0);
        clr_stim(); start = 1'b0; ref_step = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n1 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cnt0_clk) n1++;
        end
        chk("post_reset_cnt0", n1, 0);
        chk("post_reset_outputs", ovec(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
